// File: rtl/systolic_pe.sv
// systolic_pe
// Processing element for an output-stationary systolic matrix multiplier.
// Operands arrive from the left and top neighbours, are multiplied and
// accumulated locally, and are forwarded right/down one cycle later.
// Finished tile results leave through a per-column drain shift chain:
// a drain pulse emits this PE's own result and then passes the ROW
// words coming from the PEs above, while MACs continue into a fresh
// accumulator so the next tile never stalls.
module systolic_pe #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2*WIDTH+4,
    parameter bit SIGNED    = 1'b1,
    parameter bit SATURATE  = 1'b1,
    parameter int ROW       = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     inp_left,
    input  logic                 inp_valid_left,
    input  logic [WIDTH-1:0]     inp_top,
    input  logic                 inp_valid_top,
    output logic [WIDTH-1:0]     out_right,
    output logic                 out_valid_right,
    output logic [WIDTH-1:0]     out_bottom,
    output logic                 out_valid_bottom,
    input  logic                 drain,
    input  logic [ACC_WIDTH-1:0] drain_in,
    input  logic                 drain_in_valid,
    output logic [ACC_WIDTH-1:0] drain_out,
    output logic                 drain_out_valid,
    output logic                 overflow,
    output logic                 busy
);

    // Product width and the one-bit-wider adder width that holds any
    // sum of an accumulator value and a product exactly.
    localparam int PROD_W = 2*WIDTH;
    localparam int EXT_W  = ACC_WIDTH + 1;
    // Pass counter needs at least one bit even when ROW is zero.
    localparam int CNT_W  = (ROW > 0) ? $clog2(ROW + 1) : 1;

    localparam logic [CNT_W-1:0] ROW_CNT = CNT_W'(ROW);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------

    // Extend an operand to product width according to signedness.
    function automatic logic [PROD_W-1:0] extend_operand(input logic [WIDTH-1:0] v);
        logic [PROD_W-1:0] r;
        if (SIGNED) begin
            r = {{WIDTH{v[WIDTH-1]}}, v};
        end else begin
            r = {{WIDTH{1'b0}}, v};
        end
        return r;
    endfunction

    // Extend the accumulator by one guard bit according to signedness.
    function automatic logic [EXT_W-1:0] extend_acc(input logic [ACC_WIDTH-1:0] v);
        logic [EXT_W-1:0] r;
        if (SIGNED) begin
            r = {v[ACC_WIDTH-1], v};
        end else begin
            r = {1'b0, v};
        end
        return r;
    endfunction

    // Extend the product to adder width according to signedness.
    function automatic logic [EXT_W-1:0] extend_prod(input logic [PROD_W-1:0] p);
        logic [EXT_W-1:0] r;
        if (SIGNED) begin
            r = {{(EXT_W-PROD_W){p[PROD_W-1]}}, p};
        end else begin
            r = {{(EXT_W-PROD_W){1'b0}}, p};
        end
        return r;
    endfunction

    // The exact sum lies outside the accumulator range when the guard bit
    // disagrees with the accumulator sign bit (signed) or is set (unsigned).
    function automatic logic sum_overflows(input logic [EXT_W-1:0] s);
        logic r;
        if (SIGNED) begin
            r = s[EXT_W-1] ^ s[EXT_W-2];
        end else begin
            r = s[EXT_W-1];
        end
        return r;
    endfunction

    // Clamp value for an out-of-range sum; neg selects the signed minimum.
    function automatic logic [ACC_WIDTH-1:0] clamp_value(input logic neg);
        logic [ACC_WIDTH-1:0] r;
        if (!SIGNED) begin
            r = {ACC_WIDTH{1'b1}};
        end else if (neg) begin
            r = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        end else begin
            r = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ACC_WIDTH-1:0] acc_r;
    logic                 overflow_r;
    logic [0:0]           state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 busy_r;
    logic [ACC_WIDTH-1:0] drain_out_r;
    logic                 drain_out_valid_r;
    logic [WIDTH-1:0]     out_right_r;
    logic                 out_valid_right_r;
    logic [WIDTH-1:0]     out_bottom_r;
    logic                 out_valid_bottom_r;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic                 mac_s;
    logic [PROD_W-1:0]    left_ext_s;
    logic [PROD_W-1:0]    top_ext_s;
    logic [PROD_W-1:0]    product_s;
    logic [EXT_W-1:0]     prod_ext_s;
    logic [EXT_W-1:0]     sum_s;
    logic                 sum_ovf_s;
    logic [ACC_WIDTH-1:0] mac_result_s;
    logic [ACC_WIDTH-1:0] fresh_s;
    logic                 start_drain_s;

    assign mac_s      = inp_valid_left & inp_valid_top;
    assign left_ext_s = extend_operand(inp_left);
    assign top_ext_s  = extend_operand(inp_top);
    // Low PROD_W bits of the extended multiply are the exact product in
    // both signed and unsigned mode.
    assign product_s  = left_ext_s * top_ext_s;
    assign prod_ext_s = extend_prod(product_s);
    assign sum_s      = extend_acc(acc_r) + prod_ext_s;
    assign sum_ovf_s  = sum_overflows(sum_s);

    // The product always fits in ACC_WIDTH, so a fresh accumulator is
    // just the low bits of the extended product.
    assign fresh_s    = mac_s ? prod_ext_s[ACC_WIDTH-1:0] : {ACC_WIDTH{1'b0}};

    assign start_drain_s = (state_r == ST_RUN) && drain;

    // Select wrapped or clamped accumulation result.
    always_comb begin
        mac_result_s = sum_s[ACC_WIDTH-1:0];
        if (sum_ovf_s && SATURATE) begin
            mac_result_s = clamp_value(sum_s[EXT_W-1]);
        end else begin
            mac_result_s = sum_s[ACC_WIDTH-1:0];
        end
    end

    // Next accumulator and sticky overflow: drain or clear restart the tile.
    logic [ACC_WIDTH-1:0] acc_nxt_s;
    logic                 overflow_nxt_s;

    always_comb begin
        acc_nxt_s      = acc_r;
        overflow_nxt_s = overflow_r;
        if (start_drain_s || clear) begin
            acc_nxt_s      = fresh_s;
            overflow_nxt_s = 1'b0;
        end else if (mac_s) begin
            acc_nxt_s      = mac_result_s;
            overflow_nxt_s = overflow_r | sum_ovf_s;
        end else begin
            acc_nxt_s      = acc_r;
            overflow_nxt_s = overflow_r;
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    logic [0:0]           state_nxt_s;
    logic [CNT_W-1:0]     cnt_nxt_s;
    logic [ACC_WIDTH-1:0] drain_out_nxt_s;
    logic                 drain_out_valid_nxt_s;

    // Emit own result on a drain pulse, then pass ROW upstream words.
    always_comb begin
        state_nxt_s           = state_r;
        cnt_nxt_s             = cnt_r;
        drain_out_nxt_s       = drain_out_r;
        drain_out_valid_nxt_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (drain) begin
                    drain_out_nxt_s       = acc_r;
                    drain_out_valid_nxt_s = 1'b1;
                    cnt_nxt_s             = ROW_CNT;
                    state_nxt_s           = (ROW > 0) ? ST_DRAIN : ST_RUN;
                end else begin
                    drain_out_valid_nxt_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                drain_out_nxt_s       = drain_in;
                drain_out_valid_nxt_s = drain_in_valid;
                cnt_nxt_s             = cnt_r - CNT_ONE;
                if (cnt_r <= CNT_ONE) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s           = ST_RUN;
                cnt_nxt_s             = {CNT_W{1'b0}};
                drain_out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Accumulator and sticky overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_r      <= {ACC_WIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            acc_r      <= acc_nxt_s;
            overflow_r <= overflow_nxt_s;
        end
    end

    // Drain FSM state, pass counter, busy flag and drain chain output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r           <= ST_RUN;
            cnt_r             <= {CNT_W{1'b0}};
            busy_r            <= 1'b0;
            drain_out_r       <= {ACC_WIDTH{1'b0}};
            drain_out_valid_r <= 1'b0;
        end else begin
            state_r           <= state_nxt_s;
            cnt_r             <= cnt_nxt_s;
            busy_r            <= (state_nxt_s == ST_DRAIN);
            drain_out_r       <= drain_out_nxt_s;
            drain_out_valid_r <= drain_out_valid_nxt_s;
        end
    end

    // Operand forwarding: unconditional one-cycle copy of data and valids.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_right_r        <= {WIDTH{1'b0}};
            out_valid_right_r  <= 1'b0;
            out_bottom_r       <= {WIDTH{1'b0}};
            out_valid_bottom_r <= 1'b0;
        end else begin
            out_right_r        <= inp_left;
            out_valid_right_r  <= inp_valid_left;
            out_bottom_r       <= inp_top;
            out_valid_bottom_r <= inp_valid_top;
        end
    end

    assign out_right        = out_right_r;
    assign out_valid_right  = out_valid_right_r;
    assign out_bottom       = out_bottom_r;
    assign out_valid_bottom = out_valid_bottom_r;
    assign drain_out        = drain_out_r;
    assign drain_out_valid  = drain_out_valid_r;
    assign overflow         = overflow_r;
    assign busy             = busy_r;

endmodule

// File: tb/tb_systolic_pe.sv
// Testbench for systolic_pe: a saturating ROW=2 element and a wrapping
// ROW=0 element share one stimulus stream. Drain words are predicted by
// an integer model and compared through per-DUT scoreboard queues.
module tb_systolic_pe;

    localparam int     W    = 8;
    localparam int     AW   = 20;
    localparam int     ROWN = 2;
    localparam longint AMAX = 64'sd524287;
    localparam longint AMIN = -64'sd524288;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic [W-1:0]  il = 8'h00;
    logic [W-1:0]  it = 8'h00;
    logic          vl = 1'b0;
    logic          vt = 1'b0;
    logic          drain = 1'b0;
    logic [AW-1:0] di = 20'h0;
    logic          div = 1'b0;
    logic [AW-1:0] zero_word = 20'h0;
    logic          zero_bit = 1'b0;

    logic [W-1:0]  r1, b1, r2, b2;
    logic          vr1, vb1, vr2, vb2;
    logic [AW-1:0] do1, do2;
    logic          dv1, dv2, ov1, ov2, busy1, busy2;

    systolic_pe #(.WIDTH(W), .ACC_WIDTH(AW), .SIGNED(1'b1), .SATURATE(1'b1), .ROW(ROWN)) u_sat (
        .clock(clock), .reset(reset), .clear(clear),
        .inp_left(il), .inp_valid_left(vl), .inp_top(it), .inp_valid_top(vt),
        .out_right(r1), .out_valid_right(vr1), .out_bottom(b1), .out_valid_bottom(vb1),
        .drain(drain), .drain_in(di), .drain_in_valid(div),
        .drain_out(do1), .drain_out_valid(dv1), .overflow(ov1), .busy(busy1)
    );

    systolic_pe #(.WIDTH(W), .ACC_WIDTH(AW), .SIGNED(1'b1), .SATURATE(1'b0), .ROW(0)) u_wrap (
        .clock(clock), .reset(reset), .clear(clear),
        .inp_left(il), .inp_valid_left(vl), .inp_top(it), .inp_valid_top(vt),
        .out_right(r2), .out_valid_right(vr2), .out_bottom(b2), .out_valid_bottom(vb2),
        .drain(drain), .drain_in(zero_word), .drain_in_valid(zero_bit),
        .drain_out(do2), .drain_out_valid(dv2), .overflow(ov2), .busy(busy2)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    logic [AW-1:0] exp1[$];
    logic [AW-1:0] exp2[$];

    // Model state
    longint m1 = 0;
    longint w2 = 0;
    logic   o1 = 1'b0;
    logic   o2 = 1'b0;
    int     passes_left = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // One clock of stimulus; updates the model and the scoreboards.
    task automatic drive(input logic vl_a, input logic vt_a, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic dr, input logic cl,
                         input logic dv_a, input logic [AW-1:0] d_a);
        longint        prod;
        logic          mac;
        logic          take1;
        logic [AW-1:0] t;
        mac   = vl_a && vt_a;
        prod  = longint'($signed(a)) * longint'($signed(b));
        take1 = dr && (passes_left == 0);
        if (passes_left > 0) begin
            if (dv_a) exp1.push_back(d_a);
            passes_left--;
        end else if (dr) begin
            t = m1[AW-1:0];
            exp1.push_back(t);
            passes_left = ROWN;
        end
        if (take1 || cl) begin
            m1 = mac ? prod : 64'sd0;
            o1 = 1'b0;
        end else if (mac) begin
            m1 = m1 + prod;
            if (m1 > AMAX) begin m1 = AMAX; o1 = 1'b1; end
            else if (m1 < AMIN) begin m1 = AMIN; o1 = 1'b1; end
        end
        if (dr) begin
            t = w2[AW-1:0];
            exp2.push_back(t);
        end
        if (dr || cl) begin
            w2 = mac ? prod : 64'sd0;
            o2 = 1'b0;
        end else if (mac) begin
            w2 = w2 + prod;
            if (w2 > AMAX || w2 < AMIN) begin
                o2 = 1'b1;
                t  = w2[AW-1:0];
                w2 = longint'($signed(t));
            end
        end
        il = a; it = b; vl = vl_a; vt = vt_a;
        drain = dr; clear = cl; div = dv_a; di = d_a;
        cyc();
        vl = 1'b0; vt = 1'b0; drain = 1'b0; clear = 1'b0; div = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 20'h0);
    endtask

    task automatic mac(input logic [W-1:0] a, input logic [W-1:0] b);
        drive(1'b1, 1'b1, a, b, 1'b0, 1'b0, 1'b0, 20'h0);
    endtask

    task automatic do_drain();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 20'h0);
    endtask

    // Scoreboard: compare every valid drain word against the queue head.
    always @(negedge clock) begin
        if (!reset) begin
            if (dv1) begin
                if (exp1.size() == 0) check_value("sat_drain_unexpected", 32'(dv1), 32'd0);
                else check_value("sat_drain_word", 32'(do1), 32'(exp1.pop_front()));
            end
            if (dv2) begin
                if (exp2.size() == 0) check_value("wrap_drain_unexpected", 32'(dv2), 32'd0);
                else check_value("wrap_drain_word", 32'(do2), 32'(exp2.pop_front()));
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_value("rst_out_right", 32'(r1), 32'd0);
        check_value("rst_valids", 32'({vr1, vb1, dv1, ov1, busy1}), 32'd0);
        check_value("rst_drain_out", 32'(do1), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Forwarding, including invalid data passing through
        mac(8'h12, 8'h34);
        check_value("fwd_right", 32'(r1), 32'h12);
        check_value("fwd_bottom", 32'(b1), 32'h34);
        check_value("fwd_valids", 32'({vr1, vb1}), 32'h3);
        drive(1'b0, 1'b0, 8'hAB, 8'hCD, 1'b0, 1'b0, 1'b0, 20'h0);
        check_value("fwd_invalid_valids", 32'({vr1, vb1}), 32'h0);
        check_value("fwd_invalid_data", 32'({r1, b1}), 32'hABCD);
        do_drain();
        check_value("busy_after_drain", 32'({busy1, busy2}), 32'h2);
        idle(2);

        // Signed MAC: (-3)*5 four times; left-only cycle is ignored
        for (int i = 0; i < 4; i++) mac(8'hFD, 8'h05);
        drive(1'b1, 1'b0, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0, 20'h0);
        do_drain();
        idle(2);

        // Saturation / wrap at the accumulator boundary
        for (int i = 0; i < 32; i++) mac(8'h7F, 8'h7F);
        check_value("ovf_at_limit", 32'({ov1, ov2}), 32'({o1, o2}));
        mac(8'h7F, 8'h7F);
        check_value("ovf_sat", 32'(ov1), 32'd1);
        check_value("ovf_wrap", 32'(ov2), 32'd1);
        do_drain();
        check_value("ovf_cleared", 32'({ov1, ov2}), 32'd0);
        idle(2);

        // Drain chain with pass-through; second drain pulse ignored
        mac(8'h07, 8'h01);
        do_drain();
        check_value("chain_busy_t1", 32'(busy1), 32'd1);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 20'hAAAAA);
        check_value("chain_busy_t2", 32'(busy1), 32'd1);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 20'hBBBBB);
        check_value("chain_busy_t3", 32'(busy1), 32'd0);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 20'hCCCCC);
        idle(1);

        // Overlap: MAC in drain cycle seeds the next tile
        mac(8'h0A, 8'h0A);
        drive(1'b1, 1'b1, 8'h02, 8'h03, 1'b1, 1'b0, 1'b0, 20'h0);
        idle(2);
        do_drain();
        idle(2);

        // Clear with MAC, then clear together with drain
        mac(8'h05, 8'h05);
        drive(1'b1, 1'b1, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 20'h0);
        mac(8'h04, 8'h04);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 20'h0);
        idle(2);
        do_drain();
        idle(2);

        // Reset in the middle of a drain
        mac(8'h09, 8'h09);
        do_drain();
        idle(1);
        reset = 1'b1;
        #1;
        check_value("mid_rst_busy", 32'(busy1), 32'd0);
        check_value("mid_rst_outs", 32'({dv1, ov1, vr1, vb1}), 32'd0);
        check_value("mid_rst_data", 32'({do1, r1, b1}), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        m1 = 0; w2 = 0; o1 = 1'b0; o2 = 1'b0; passes_left = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 20'h55555);
            check_value("post_rst_no_valid", 32'(dv1), 32'd0);
        end
        idle(2);

        check_value("sat_queue_empty", 32'(exp1.size()), 32'd0);
        check_value("wrap_queue_empty", 32'(exp2.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/systolic_pe.md
# systolic_pe

Parametrised processing element for output-stationary systolic matrix multipliers. Each cycle it multiplies valid operands arriving from the left and top neighbours and adds the product to a local accumulator. It forwards both operands with their valid flags to the right and bottom neighbours one cycle later. Signedness, accumulator width and saturation are selectable, and results leave through a per-column drain shift chain without stalling the next tile.

## Interface
- WIDTH, 8, operand width
- ACC_WIDTH, 2*WIDTH+4, accumulator width (must be ≥ 2*WIDTH)
- SIGNED, 1, 1 = two's-complement operands/accumulator, 0 = unsigned
- SATURATE, 1, 1 = clamp on accumulator overflow, 0 = wrap
- ROW, 0, row index in column (0 = top); number of drain words passed through from above

- clock  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- clear  in  1  sync: zero accumulator and overflow
- inp_left / inp_valid_left  in  WIDTH / 1  row operand and its valid
- inp_top / inp_valid_top  in  WIDTH / 1  column operand and its valid
- out_right / out_valid_right  out  WIDTH / 1  registered copy of left inputs
- out_bottom / out_valid_bottom  out  WIDTH / 1  registered copy of top inputs
- drain  in  1  one-cycle pulse: emit result, start drain
- drain_in / drain_in_valid  in  ACC_WIDTH / 1  drain chain from PE above (top PE ties to 0)
- drain_out / drain_out_valid  out  ACC_WIDTH / 1  drain chain to PE below
- overflow  out  1  sticky: accumulation overflowed since last clear/drain
- busy  out  1  high while in DRAIN state

## Operation
- MAC fires when inp_valid_left && inp_valid_top; product is 2*WIDTH bits, sign-extended (SIGNED=1) or zero-extended to ACC_WIDTH+1 before add.
- Overflow: sum outside ACC_WIDTH range. SATURATE=1: clamp to max/min (unsigned: all-ones) and set overflow. SATURATE=0: keep low ACC_WIDTH bits and set overflow.
- Forwarding is independent of MAC: data and valid registers always load from inputs; data bits are don't-care when valid=0 but are still forwarded.
- clear: acc ← (MAC ? product : 0); overflow ← 0. Does not affect forwarding or drain.
- FSM states: RUN, DRAIN; pass counter cnt (width clog2(ROW+1)).
- RUN + drain: drain_out ← acc, drain_out_valid ← 1, acc ← (MAC ? product : 0), overflow ← 0, cnt ← ROW. Next state: DRAIN if ROW>0, else RUN.
- RUN without drain: drain_out_valid ← 0.
- DRAIN: drain_out ← drain_in, drain_out_valid ← drain_in_valid, cnt ← cnt−1. Return to RUN when cnt reaches 1. MACs continue into the fresh accumulator. drain pulses are ignored.
- Column order on bottom PE drain_out: own row N−1 first, then N−2 … 0.

## Timing
- Reset (async) values: all outputs 0, acc 0, state RUN, cnt 0. Reset mid-drain aborts the drain with no further drain_out_valid.
- Forwarding latency: 1 cycle.
- MAC result is visible in acc the cycle after the operands; a drain in cycle t captures acc including MACs up to t−1. A MAC in cycle t goes to the new tile.
- drain in cycle t: own result on drain_out at t+1. PE at ROW r passes upstream words at t+2 … t+r+1 and is back in RUN (busy=0) at t+r+1.
- clear and drain in the same cycle: drain wins for drain_out (old acc emitted); acc ← MAC ? product : 0.

## Test plan
- Forwarding: inp_left=0x12, inp_top=0x34, both valid → next cycle out_right=0x12, out_bottom=0x34, both valids 1; subsequent drain outputs 0x003A8.
- Signed MAC: SIGNED=1, (−3)×5 for 4 valid cycles, then drain → drain_out=0xFFFC4 (−60), valid for exactly one cycle; one valid-only-left cycle does not change acc.
- Saturation: SIGNED=1, ACC_WIDTH=20, 127×127 × 32 → 516128, overflow=0; 33rd MAC → 524287, overflow=1. Same with SATURATE=0 → −516319, overflow=1.
- Drain chain, ROW=2: drain at t (acc=7); drain_in=A at t+1, B at t+2 → drain_out 7@t+1, A@t+2, B@t+3; busy=0 at t+3; second drain at t+2 ignored.
- Overlap: acc=100, drain with MAC 2×3 in same cycle → drain_out=100, acc=6; next drain emits 6.
- Reset mid-drain: ROW=3, assert reset at t+2 → all outputs 0 immediately, busy=0, drain_out_valid stays 0 after release.
